// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch stage, directly upstream of ID.
//
// Holds the PC and issues one instruction-SRAM read per cycle. Branch/jump
// redirects from ID are applied on the next fetch; the instruction fetched in
// the redirect cycle is the delay slot and is not squashed. Under stall[0]
// the stage freezes. A redirect that arrives while frozen is parked and
// applied when the stall releases. If several redirects arrive during one
// stall, the newest one wins.
//
// Ports:
//   clk              in   1   stage clock
//   rst              in   1   asynchronous, active-low reset
//   stall            in   6   pipeline stall vector, bit 0 freezes this stage
//   br_bus           in  33   {br_e, br_addr[31:0]} from ID, valid one cycle
//   if_to_id_bus     out 33   {ce, pc[31:0]} of the current fetch
//   inst_sram_en     out  1   SRAM read enable
//   inst_sram_wen    out  4   tied to 0 (fetch never writes)
//   inst_sram_addr   out 32   fetch address
//   inst_sram_wdata  out 32   tied to 0
//   if_excp_adel     out  1   misaligned fetch flag (IF_ALIGN_CHECK_EN only)
//
// Build option:
//   IF_ALIGN_CHECK_EN  when defined, flags a misaligned PC on if_excp_adel
//                      and suppresses the SRAM access for that fetch. ID
//                      still sees ce=1 and the faulting PC.
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
//
// FSM states
//   state | meaning
//   ------+------------------------------------------------------------
//   BOOT  | out of reset, no valid fetch yet; waits for stall release
//   RUN   | fetching one instruction per unstalled cycle
//   HOLD  | stalled with a redirect parked in br_pend_addr_q
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_excp_adel
`endif
);

    localparam logic        STOP       = 1'b1;
    localparam logic [31:0] PC_STEP    = 32'd4;
    // Parked in pc_reg during reset so the first fetch lands on RESET_PC.
    localparam logic [31:0] PC_RST_VAL = RESET_PC - PC_STEP;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // Input decode
    // -----------------------------------------------------------------------
    logic        stop;
    logic        br_e;
    logic [31:0] br_addr;

    assign stop    = (stall[0] == STOP);
    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Only stall[0] belongs to this stage; the rest of the vector is for
    // downstream stages.
    logic unused_stall_hi;
    assign unused_stall_hi = ^stall[5:1];

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_e      state_q,        state_d;
    logic [31:0] pc_reg_q,       pc_reg_d;
    logic        ce_reg_q,       ce_reg_d;
    logic        br_pend_q,      br_pend_d;
    logic [31:0] br_pend_addr_q, br_pend_addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= BOOT;
            pc_reg_q       <= PC_RST_VAL;
            ce_reg_q       <= 1'b0;
            br_pend_q      <= 1'b0;
            br_pend_addr_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_reg_q       <= pc_reg_d;
            ce_reg_q       <= ce_reg_d;
            br_pend_q      <= br_pend_d;
            br_pend_addr_q <= br_pend_addr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic [31:0] pc_seq;

    // 32-bit add wraps naturally: 32'hffff_fffc + 4 = 0.
    assign pc_seq = pc_reg_q + PC_STEP;

    always_comb begin
        state_d        = state_q;
        pc_reg_d       = pc_reg_q;
        ce_reg_d       = ce_reg_q;
        br_pend_d      = br_pend_q;
        br_pend_addr_d = br_pend_addr_q;

        unique case (state_q)
            BOOT: begin
                // Redirects are meaningless before the first fetch.
                if (!stop) begin
                    pc_reg_d = RESET_PC;
                    ce_reg_d = 1'b1;
                    state_d  = RUN;
                end else begin
                    ce_reg_d = 1'b0;
                end
            end

            RUN: begin
                if (!stop) begin
                    pc_reg_d = br_e ? br_addr : pc_seq;
                    ce_reg_d = 1'b1;
                end else if (br_e) begin
                    br_pend_d      = 1'b1;
                    br_pend_addr_d = br_addr;
                    state_d        = HOLD;
                end
            end

            HOLD: begin
                if (stop) begin
                    if (br_e) begin
                        br_pend_addr_d = br_addr;
                    end
                end else begin
                    // A redirect arriving on the release cycle is younger
                    // than the parked one, so it takes priority.
                    pc_reg_d  = br_e ? br_addr : br_pend_addr_q;
                    ce_reg_d  = 1'b1;
                    br_pend_d = 1'b0;
                    state_d   = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign if_to_id_bus    = {ce_reg_q, pc_reg_q};
    assign inst_sram_addr  = pc_reg_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;

`ifdef IF_ALIGN_CHECK_EN
    // Tracks pc_reg exactly, so the flag always describes the PC on the bus.
    logic adel_q, adel_d;

    assign adel_d = (pc_reg_d[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    assign if_excp_adel = adel_q;
    assign inst_sram_en = ce_reg_q & ~adel_q;
`else
    assign inst_sram_en = ce_reg_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
//
// Reference model: a fetch PC, a valid flag, a "booted" flag and an optional
// parked redirect. On every edge: before boot, a release starts fetching at
// RESET_PC; while stalled, a redirect replaces whatever is parked; when not
// stalled the next PC is the live redirect, else the parked one, else PC+4.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_excp_adel;
`endif

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .if_excp_adel    (if_excp_adel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_booted;
    logic        m_pend;
    logic [31:0] m_pend_addr;

    function automatic logic exp_en();
`ifdef IF_ALIGN_CHECK_EN
        return m_ce && (m_pc[1:0] == 2'b00);
`else
        return m_ce;
`endif
    endfunction

    task automatic model_reset();
        m_pc        = RESET_PC - 32'd4;
        m_ce        = 1'b0;
        m_booted    = 1'b0;
        m_pend      = 1'b0;
        m_pend_addr = 32'd0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, and
    // return 1 ns after the edge with br_bus cleared.
    task automatic step(input logic st, input logic be, input logic [31:0] ba);
        logic [4:0] hi;
        hi     = 5'($urandom_range(0, 31));
        stall  = {hi, st};
        br_bus = {be, ba};
        @(posedge clk);
        if (!m_booted) begin
            if (!st) begin
                m_pc     = RESET_PC;
                m_ce     = 1'b1;
                m_booted = 1'b1;
            end
        end else if (st) begin
            if (be) begin
                m_pend      = 1'b1;
                m_pend_addr = ba;
            end
        end else begin
            m_pc   = be ? ba : (m_pend ? m_pend_addr : m_pc + 32'd4);
            m_pend = 1'b0;
            m_ce   = 1'b1;
        end
        #1;
        br_bus = 33'd0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        stall  = 6'd0;
        br_bus = 33'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_en: got %b want 0", inst_sram_en);
        end
        tests_run++;
        if (if_to_id_bus !== {1'b0, RESET_PC - 32'd4}) begin
            tests_failed++;
            $display("FAIL reset_bus: got %h want %h", if_to_id_bus, {1'b0, RESET_PC - 32'd4});
        end
        tests_run++;
        if (inst_sram_wen !== 4'd0 || inst_sram_wdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_wr: got wen=%h wdata=%h want 0/0", inst_sram_wen, inst_sram_wdata);
        end
`ifdef IF_ALIGN_CHECK_EN
        tests_run++;
        if (if_excp_adel !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_adel: got %b want 0", if_excp_adel);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_boot();
        logic [31:0] want [3];
        want[0] = 32'hbfc0_0000;
        want[1] = 32'hbfc0_0004;
        want[2] = 32'hbfc0_0008;
        // A stalled boot cycle with a redirect must change nothing.
        step(1'b1, 1'b1, 32'h1234_5670);
        tests_run++;
        if (if_to_id_bus !== {1'b0, RESET_PC - 32'd4}) begin
            tests_failed++;
            $display("FAIL boot_stalled: got %h want %h", if_to_id_bus, {1'b0, RESET_PC - 32'd4});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            tests_run++;
            if (inst_sram_addr !== want[i] || inst_sram_en !== 1'b1) begin
                tests_failed++;
                $display("FAIL boot_seq%0d: got addr=%h en=%b want addr=%h en=1",
                         i, inst_sram_addr, inst_sram_en, want[i]);
            end
        end
    endtask

    task automatic test_branch();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'hbfc0_0010) begin
            tests_failed++;
            $display("FAIL branch_pre: got %h want bfc00010", inst_sram_addr);
        end
        step(1'b0, 1'b1, 32'hbfc0_0100);
        tests_run++;
        if (inst_sram_addr !== 32'hbfc0_0100) begin
            tests_failed++;
            $display("FAIL branch_target: got %h want bfc00100", inst_sram_addr);
        end
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'hbfc0_0104) begin
            tests_failed++;
            $display("FAIL branch_next: got %h want bfc00104", inst_sram_addr);
        end
    endtask

    task automatic test_stall_branch();
        step(1'b1, 1'b1, 32'hbfc0_0200);
        tests_run++;
        if (if_to_id_bus !== {1'b1, 32'hbfc0_0104}) begin
            tests_failed++;
            $display("FAIL stall_hold: got %h want 1bfc00104", if_to_id_bus);
        end
        tests_run++;
        if (dut.br_pend_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_pend: got %b want 1", dut.br_pend_q);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'hbfc0_0104) begin
            tests_failed++;
            $display("FAIL stall_hold2: got %h want bfc00104", inst_sram_addr);
        end
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'hbfc0_0200) begin
            tests_failed++;
            $display("FAIL stall_release: got %h want bfc00200", inst_sram_addr);
        end
    endtask

    task automatic test_two_redirects();
        step(1'b1, 1'b1, 32'h8000_0000);
        step(1'b1, 1'b1, 32'h8000_0040);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'h8000_0040) begin
            tests_failed++;
            $display("FAIL two_redirects: got %h want 80000040", inst_sram_addr);
        end
    endtask

    task automatic test_release_live();
        step(1'b1, 1'b1, 32'h8000_0000);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h8000_0080);
        tests_run++;
        if (inst_sram_addr !== 32'h8000_0080) begin
            tests_failed++;
            $display("FAIL release_live: got %h want 80000080", inst_sram_addr);
        end
        tests_run++;
        if (dut.br_pend_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_pend: got %b want 0", dut.br_pend_q);
        end
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'h8000_0084) begin
            tests_failed++;
            $display("FAIL release_next: got %h want 80000084", inst_sram_addr);
        end
    endtask

    task automatic test_wrap_align();
        step(1'b0, 1'b1, 32'hffff_fffc);
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap: got %h want 00000000", inst_sram_addr);
        end
        step(1'b0, 1'b1, 32'hbfc0_0102);
        tests_run++;
        if (if_to_id_bus !== {1'b1, 32'hbfc0_0102}) begin
            tests_failed++;
            $display("FAIL misalign_bus: got %h want 1bfc00102", if_to_id_bus);
        end
`ifdef IF_ALIGN_CHECK_EN
        tests_run++;
        if (if_excp_adel !== 1'b1 || inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_adel: got adel=%b en=%b want adel=1 en=0",
                     if_excp_adel, inst_sram_en);
        end
`else
        tests_run++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc0_0102) begin
            tests_failed++;
            $display("FAIL misalign_issue: got en=%b addr=%h want en=1 addr=bfc00102",
                     inst_sram_en, inst_sram_addr);
        end
`endif
        step(1'b0, 1'b1, 32'hbfc0_0300);
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            logic        st;
            logic        be;
            logic [31:0] ba;
            st = ($urandom_range(0, 99) < 40);
            be = ($urandom_range(0, 99) < 25);
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            step(st, be, ba);
            tests_run++;
            if (if_to_id_bus !== {m_ce, m_pc} || inst_sram_addr !== m_pc) begin
                tests_failed++;
                $display("FAIL random_pc[%0d]: got bus=%h addr=%h want bus=%h addr=%h",
                         i, if_to_id_bus, inst_sram_addr, {m_ce, m_pc}, m_pc);
            end
            tests_run++;
            if (inst_sram_en !== exp_en()) begin
                tests_failed++;
                $display("FAIL random_en[%0d]: got %b want %b", i, inst_sram_en, exp_en());
            end
`ifdef IF_ALIGN_CHECK_EN
            tests_run++;
            if (if_excp_adel !== (m_pc[1:0] != 2'b00)) begin
                tests_failed++;
                $display("FAIL random_adel[%0d]: got %b want %b",
                         i, if_excp_adel, (m_pc[1:0] != 2'b00));
            end
`endif
        end
    endtask

    task automatic test_reset_midop();
        // Park a redirect, then reset between edges; it must be discarded.
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h8000_1000);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (if_to_id_bus !== {1'b0, RESET_PC - 32'd4} || inst_sram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_reset: got bus=%h en=%b want bus=%h en=0",
                     if_to_id_bus, inst_sram_en, {1'b0, RESET_PC - 32'd4});
        end
        tests_run++;
        if (dut.br_pend_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_pend: got %b want 0", dut.br_pend_q);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== RESET_PC || inst_sram_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_reboot: got addr=%h en=%b want addr=%h en=1",
                     inst_sram_addr, inst_sram_en, RESET_PC);
        end
        step(1'b0, 1'b0, 32'd0);
        tests_run++;
        if (inst_sram_addr !== RESET_PC + 32'd4) begin
            tests_failed++;
            $display("FAIL midop_seq: got %h want %h", inst_sram_addr, RESET_PC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch();
        test_stall_branch();
        test_two_redirects();
        test_release_live();
        test_wrap_align();
        test_random(400);
        test_reset_midop();
        test_random(200);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
